convolution_decoder: RTL and testbench

- Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code used by the per-byte encoder slices.
- Accepts one 16-bit codeword and recovers the 8-bit message it carries; mirrors the encoder slice interface so a top level can instance 24 of them for a 384-bit block.
- Processes one trellis step per clock, then traces back one step per clock.

---
 rtl/convolution_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_convolution_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/convolution_decoder.sv
`default_nettype none
// ============================================================================
// Module   : convolution_decoder
// Purpose  : Hard-decision Viterbi decoder for the rate-1/2, K=3 code
//            (g0 = 111, g1 = 101). It recovers one 8-bit message from one
//            16-bit codeword. The decoder performs one add-compare-select
//            (ACS) trellis step per clock and then one traceback step per
//            clock, so each codeword takes 18 cycles.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous active-high reset; returns to IDLE and
//                         clears all state
//            start      - sampled in IDLE only; latches code_in
//            code_in    - codeword; pair k = {code_in[2k+1], code_in[2k]},
//                         with the g0 bit in the even position
//            m_text_out - decoded message; held until the next done
//            busy       - high while decoding (after edges 1..16)
//            done       - one-cycle pulse when m_text_out is updated
//            err_count  - winning path metric; present only with
//                         CONV_DEC_ERR_CNT_EN
// Options  : `define CONV_DEC_ERR_CNT_EN adds the err_count port/register
// Revision : 1.0 - initial release
// ============================================================================
module convolution_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] code_in,
   output logic [7:0]  m_text_out,
   output logic        busy,
   output logic        done
`ifdef CONV_DEC_ERR_CNT_EN
   ,
   output logic [5:0]  err_count
`endif
);

   // Every state except the all-zero start state begins with a metric
   // large enough that it never beats the true start state.
   localparam logic [5:0] c_PM_INIT_FAR = 6'd20;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACS  = 2'd1,
      S_TB   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [2:0]  r_cnt;
   logic [15:0] r_code;
   logic [5:0]  r_pm   [0:3];
   logic [3:0]  r_surv [0:7];
   logic [1:0]  r_tb_state;
   logic [7:0]  r_msg;
   logic [7:0]  r_m_text;
   logic        r_busy;
   logic        r_done;
`ifdef CONV_DEC_ERR_CNT_EN
   logic [5:0]  r_err;
`endif

   logic [1:0]  w_rx;
   logic [5:0]  w_pm_next [0:3];
   logic [3:0]  w_surv_next;
   logic [1:0]  w_best;
   logic [5:0]  w_best_pm;
   logic [1:0]  w_tb_cur;
   logic [3:0]  w_surv_row;
   logic        w_tb_bit;

   // Hamming distance between the branch output for input u from state p
   // and the received pair rx = {g1, g0}.
   function automatic logic [1:0] f_bm(input logic [1:0] p,
                                       input logic       u,
                                       input logic [1:0] rx);
      logic g0;
      logic g1;
      g0 = u ^ p[1] ^ p[0];
      g1 = u ^ p[0];
      return {1'b0, g0 ^ rx[0]} + {1'b0, g1 ^ rx[1]};
   endfunction

   // Received pair for the current ACS step.
   assign w_rx = r_code[{r_cnt, 1'b0} +: 2];

   // ------------------------------------------------------------------
   // ACS: a next state ns = {u, s1} can only be reached from {ns[0], 0}
   // or from {ns[0], 1}. The survivor bit is the s0 of the winner, which
   // is the bit that traceback shifts back into the state.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 4; gi++) begin : g_acs
      localparam logic [1:0] c_NS = 2'(gi);
      localparam logic [1:0] c_P0 = {c_NS[0], 1'b0};
      localparam logic [1:0] c_P1 = {c_NS[0], 1'b1};

      logic [5:0] w_cand0;
      logic [5:0] w_cand1;
      logic       w_take_p1;

      assign w_cand0   = r_pm[c_P0] + {4'd0, f_bm(c_P0, c_NS[1], w_rx)};
      assign w_cand1   = r_pm[c_P1] + {4'd0, f_bm(c_P1, c_NS[1], w_rx)};
      // Strict compare: a tie keeps the s0=0 predecessor.
      assign w_take_p1 = (w_cand1 < w_cand0);

      assign w_pm_next[gi]   = w_take_p1 ? w_cand1 : w_cand0;
      assign w_surv_next[gi] = w_take_p1;
   end

   // Minimum final metric. Strict compare means ties go to the lowest index.
   always_comb begin
      w_best    = 2'd0;
      w_best_pm = r_pm[0];
      for (int i = 1; i < 4; i++) begin
         if (r_pm[i] < w_best_pm) begin
            w_best_pm = r_pm[i];
            w_best    = 2'(i);
         end
      end
   end

   // The first traceback step (counter 7) starts from the best final state.
   // Each later step continues from the state that the previous step
   // registered.
   assign w_tb_cur   = (r_cnt == 3'd7) ? w_best : r_tb_state;
   assign w_surv_row = r_surv[r_cnt];
   assign w_tb_bit   = w_surv_row[w_tb_cur];

   // ------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_ACS;
         S_ACS:   if (r_cnt == 3'd7) w_state_next = S_TB;
         S_TB:    if (r_cnt == 3'd0) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM state register and datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 3'd0;
         r_code     <= 16'd0;
         r_tb_state <= 2'd0;
         r_msg      <= 8'd0;
         r_m_text   <= 8'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         for (int i = 0; i < 4; i++) r_pm[i] <= 6'd0;
         for (int i = 0; i < 8; i++) r_surv[i] <= 4'd0;
`ifdef CONV_DEC_ERR_CNT_EN
         r_err      <= 6'd0;
`endif
      end else begin
         r_state <= w_state_next;
         // busy and done are registered from the state they describe, so
         // each appears one edge after that state is entered.
         r_busy  <= (r_state == S_ACS) || (r_state == S_TB);
         r_done  <= (r_state == S_DONE);

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_code  <= code_in;
                  r_cnt   <= 3'd0;
                  r_pm[0] <= 6'd0;
                  r_pm[1] <= c_PM_INIT_FAR;
                  r_pm[2] <= c_PM_INIT_FAR;
                  r_pm[3] <= c_PM_INIT_FAR;
               end
            end
            S_ACS: begin
               for (int i = 0; i < 4; i++) r_pm[i] <= w_pm_next[i];
               r_surv[r_cnt] <= w_surv_next;
               // The counter holds at 7 so that traceback begins at step 7.
               if (r_cnt != 3'd7) r_cnt <= r_cnt + 3'd1;
            end
            S_TB: begin
               r_msg[r_cnt] <= w_tb_cur[1];
               r_tb_state   <= {w_tb_cur[0], w_tb_bit};
               if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
            end
            S_DONE: begin
               r_m_text <= r_msg;
`ifdef CONV_DEC_ERR_CNT_EN
               // Path metrics are frozen during traceback, so this is
               // still the winning metric.
               r_err    <= w_best_pm;
`endif
            end
            default: ;
         endcase
      end
   end

   assign m_text_out = r_m_text;
   assign busy       = r_busy;
   assign done       = r_done;
`ifdef CONV_DEC_ERR_CNT_EN
   assign err_count  = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_convolution_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_convolution_decoder
// Purpose  : Self-checking bench for convolution_decoder. Codewords are built
//            by a behavioural model of the encoder slice. The expected
//            message is the original message. The expected err_count is the
//            number of injected bit flips.
// Revision : 1.0 - initial release
// ============================================================================
module tb_convolution_decoder;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] code_in;
   logic [7:0]  m_text_out;
   logic        busy;
   logic        done;
`ifdef CONV_DEC_ERR_CNT_EN
   logic [5:0]  err_count;
`endif

   int n_assert;
   int n_fail;

   convolution_decoder dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .code_in    (code_in),
      .m_text_out (m_text_out),
      .busy       (busy),
      .done       (done)
`ifdef CONV_DEC_ERR_CNT_EN
      ,
      .err_count  (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Encoder slice model: a shift register fed LSB-first.
   function automatic logic [15:0] enc(input logic [7:0] msg);
      logic [15:0] c;
      logic        s1;
      logic        s0;
      c  = 16'd0;
      s1 = 1'b0;
      s0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         c[2*k]   = msg[k] ^ s1 ^ s0;
         c[2*k+1] = msg[k] ^ s0;
         s0 = s1;
         s1 = msg[k];
      end
      return c;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Call this just after a clock edge while the DUT is idle. It returns
   // one cycle after done, with the DUT idle again.
   task automatic decode_one(input logic [15:0] code, input logic [7:0] exp_msg,
                             input int exp_err, input string tag);
      logic [7:0] prev;
      int         n;
      prev    = m_text_out;
      start   = 1'b1;
      code_in = code;
      @(posedge clk); #1;                 // accepting edge 0
      start   = 1'b0;
      code_in = $urandom;                 // must not be re-sampled
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         n++;
         if (n == 8)  check({tag, "_busy"}, {15'd0, busy}, 16'd1);
         if (n == 16) check({tag, "_hold"}, {8'd0, m_text_out}, {8'd0, prev});
         if (done) break;
      end
      check({tag, "_latency"}, 16'(n), 16'd17);
      check({tag, "_msg"}, {8'd0, m_text_out}, {8'd0, exp_msg});
`ifdef CONV_DEC_ERR_CNT_EN
      check({tag, "_err"}, {10'd0, err_count}, 16'(exp_err));
`else
      if (exp_err < 0) $display("unexpected negative error count");
`endif
      check({tag, "_busy_at_done"}, {15'd0, busy}, 16'd0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
   endtask

   initial begin
      logic [7:0]  msg;
      logic [7:0]  acc_msg;
      logic [7:0]  drv_msg [0:17];
      logic [15:0] code;
      int          flips;
      int          pos;
      int          ph;

      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      code_in  = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_done", {15'd0, done}, 16'd0);
      check("rst_msg",  {8'd0, m_text_out}, 16'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed vectors, with and without a single bit error.
      decode_one(16'h0000, 8'h00, 0, "zero");
      decode_one(16'h0037, 8'h01, 0, "v37");
      decode_one(16'h555B, 8'hFF, 0, "v555B");
      decode_one(16'h0036, 8'h01, 1, "v36_err");
      decode_one(16'h555A, 8'hFF, 1, "v555A_err");

      // Assert reset mid-ACS. m_text_out is 0xFF here, so the clear is visible.
      start   = 1'b1;
      code_in = 16'h0037;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midrst_busy", {15'd0, busy}, 16'd0);
      check("midrst_done", {15'd0, done}, 16'd0);
      check("midrst_msg",  {8'd0, m_text_out}, 16'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      decode_one(16'h0037, 8'h01, 0, "after_rst");

      // Hold start high and change code_in every cycle. Only the word at
      // each IDLE edge is decoded, one codeword every 18 cycles.
      start = 1'b1;
      acc_msg = 8'h00;
      for (int c = 0; c < 3 * 18; c++) begin
         ph  = c % 18;
         msg = 8'($urandom);
         drv_msg[ph] = msg;
         code_in = enc(msg);
         @(posedge clk); #1;
         if (ph == 0) acc_msg = drv_msg[0];
         if (ph != 0) begin
            check("cont_done", {15'd0, done}, {15'd0, (ph == 17)});
            check("cont_busy", {15'd0, busy}, {15'd0, (ph <= 16)});
         end
         if (ph == 17) check("cont_msg", {8'd0, m_text_out}, {8'd0, acc_msg});
      end
      start = 1'b0;
      @(posedge clk); #1;

      // Random messages with 0 or 1 flipped bits. The last message bit
      // affects only the final pair, so a flip there is a genuine tie
      // between two paths. The tie resolves to a final bit of 0, so such
      // flips are moved to pair 6 when the last message bit is 1.
      for (int t = 0; t < 24; t++) begin
         msg   = 8'($urandom);
         flips = int'($urandom_range(0, 1));
         pos   = int'($urandom_range(0, 15));
         if (msg[7] && pos >= 14) pos = pos - 2;
         code  = enc(msg);
         if (flips == 1) code[pos] = ~code[pos];
         decode_one(code, msg, flips, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
